// File: rtl/ttl_video_timing.sv
// Purpose: pixel-rate H/V timing generator (preset-reload 9-bit counter pair) with blank/sync/load flags.
// Latency: every output is registered and updates in the clk that samples a cen rising edge (1 clk).
// Backpressure: none; free-running on cen ticks, and a steady cen (high or low) simply holds all state.
//
// Ports:
//   clk, Reset_n   system clock; synchronous active-low reset (not gated by cen)
//   cen            pixel enable; each 0->1 transition seen on clk is one pixel tick
//   hcnt, vcnt     9-bit horizontal / vertical counts
//   hblank_n       low during horizontal blank   vblank_n  low during vertical blank
//   hsync_n        low during horizontal sync    vsync_n   low during vertical sync
//   line_ld_n      low for the tick period where hcnt == H_END (drives downstream load_n)
//   frame_start    one-clk pulse on the tick where both counts reload
module ttl_video_timing #(
    parameter logic [8:0] H_START = 9'h080,
    parameter logic [8:0] H_END   = 9'h1FF,
    parameter logic [8:0] HBL_OFF = 9'h088,
    parameter logic [8:0] HBL_ON  = 9'h188,
    parameter logic [8:0] HS_ON   = 9'h1A0,
    parameter logic [8:0] HS_OFF  = 9'h1C0,
    parameter logic [8:0] V_START = 9'h0F8,
    parameter logic [8:0] V_END   = 9'h1FF,
    parameter logic [8:0] VBL_OFF = 9'h100,
    parameter logic [8:0] VBL_ON  = 9'h1F0,
    parameter logic [8:0] VS_ON   = 9'h1F8,
    parameter logic [8:0] VS_OFF  = 9'h1FC
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       cen,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       hblank_n,
    output logic       vblank_n,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       line_ld_n,
    output logic       frame_start
);

    logic       last_cen;
    logic       tick;
    logic       h_wrap;
    logic       v_wrap;
    logic [8:0] hcnt_nxt;
    logic [8:0] vcnt_nxt;

    // last_cen keeps tracking cen through reset so that releasing reset
    // with cen already high cannot fabricate a tick.
    always_ff @(posedge clk) begin
        last_cen <= cen;
    end

    assign tick = cen & ~last_cen;

    // Next-count values, mirroring the 74LS163 preset reload at terminal count.
    always_comb begin
        h_wrap   = (hcnt == H_END);
        v_wrap   = (vcnt == V_END);
        hcnt_nxt = h_wrap ? H_START : hcnt + 9'd1;
        vcnt_nxt = v_wrap ? V_START : vcnt + 9'd1;
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            hcnt        <= H_START;
            vcnt        <= V_START;
            hblank_n    <= 1'b0;
            vblank_n    <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            line_ld_n   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                hcnt <= hcnt_nxt;

                // Flags are set/reset latches keyed on the count being entered,
                // so they line up with the count value in the same clk.
                if (hcnt_nxt == HBL_OFF) begin
                    hblank_n <= 1'b1;
                end else if (hcnt_nxt == HBL_ON) begin
                    hblank_n <= 1'b0;
                end

                if (hcnt_nxt == HS_ON) begin
                    hsync_n <= 1'b0;
                end else if (hcnt_nxt == HS_OFF) begin
                    hsync_n <= 1'b1;
                end

                // Low for exactly the tick period spent at H_END; downstream
                // counters sharing cen see the load at the following tick.
                line_ld_n <= (hcnt_nxt != H_END);

                if (h_wrap) begin
                    vcnt <= vcnt_nxt;

                    if (vcnt_nxt == VBL_OFF) begin
                        vblank_n <= 1'b1;
                    end else if (vcnt_nxt == VBL_ON) begin
                        vblank_n <= 1'b0;
                    end

                    if (vcnt_nxt == VS_ON) begin
                        vsync_n <= 1'b0;
                    end else if (vcnt_nxt == VS_OFF) begin
                        vsync_n <= 1'b1;
                    end

                    frame_start <= v_wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_ttl_video_timing.sv
// Bench for ttl_video_timing: one instance with default timing, one with a tiny
// frame so frame wraps happen often; both compared every clk against a model.
// Flags are predicted from count ranges rather than set/reset events.
module tb_ttl_video_timing;

    typedef struct packed {
        logic [8:0] hs, he, hbo, hbn, hso, hsf;
        logic [8:0] vs, ve, vbo, vbn, vso, vsf;
    } tp_t;

    localparam tp_t P0 = '{hs: 9'h080, he: 9'h1FF, hbo: 9'h088, hbn: 9'h188, hso: 9'h1A0, hsf: 9'h1C0,
                           vs: 9'h0F8, ve: 9'h1FF, vbo: 9'h100, vbn: 9'h1F0, vso: 9'h1F8, vsf: 9'h1FC};
    localparam tp_t P1 = '{hs: 9'h1F0, he: 9'h1FF, hbo: 9'h1F2, hbn: 9'h1FC, hso: 9'h1FD, hsf: 9'h1FE,
                           vs: 9'h1F8, ve: 9'h1FF, vbo: 9'h1F9, vbn: 9'h1FD, vso: 9'h1FE, vsf: 9'h1FF};
    localparam tp_t PRM [2] = '{P0, P1};

    logic       clk;
    logic       Reset_n;
    logic       cen;
    logic [8:0] d_h [2];
    logic [8:0] d_v [2];
    logic       d_hb [2];
    logic       d_vb [2];
    logic       d_hs [2];
    logic       d_vs [2];
    logic       d_ld [2];
    logic       d_fs [2];

    int n_checks = 0;
    int n_errors = 0;

    ttl_video_timing u_dut0 (
        .clk(clk), .Reset_n(Reset_n), .cen(cen),
        .hcnt(d_h[0]), .vcnt(d_v[0]), .hblank_n(d_hb[0]), .vblank_n(d_vb[0]),
        .hsync_n(d_hs[0]), .vsync_n(d_vs[0]), .line_ld_n(d_ld[0]), .frame_start(d_fs[0])
    );

    ttl_video_timing #(
        .H_START(P1.hs), .H_END(P1.he), .HBL_OFF(P1.hbo), .HBL_ON(P1.hbn), .HS_ON(P1.hso), .HS_OFF(P1.hsf),
        .V_START(P1.vs), .V_END(P1.ve), .VBL_OFF(P1.vbo), .VBL_ON(P1.vbn), .VS_ON(P1.vso), .VS_OFF(P1.vsf)
    ) u_dut1 (
        .clk(clk), .Reset_n(Reset_n), .cen(cen),
        .hcnt(d_h[1]), .vcnt(d_v[1]), .hblank_n(d_hb[1]), .vblank_n(d_vb[1]),
        .hsync_n(d_hs[1]), .vsync_n(d_vs[1]), .line_ld_n(d_ld[1]), .frame_start(d_fs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
            if (n_errors >= 100) finish_sim();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input logic [8:0] x, input logic [8:0] lo, input logic [8:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    // Packed view: {8'b0, hcnt, vcnt, hblank_n, vblank_n, hsync_n, vsync_n, line_ld_n, frame_start}
    function automatic logic [31:0] expv(input int i, input logic [8:0] h, input logic [8:0] v, input logic fs);
        tp_t p;
        p = PRM[i];
        return {8'd0, h, v, in_rng(h, p.hbo, p.hbn), in_rng(v, p.vbo, p.vbn),
                !in_rng(h, p.hso, p.hsf), !in_rng(v, p.vso, p.vsf), (h != p.he), fs};
    endfunction

    // ---------------- reference model: pixel position per instance ----------------
    logic       m_last_cen = 1'b0;
    logic       m_tick = 1'b0;
    logic       m_rst = 1'b0;
    logic       m_live = 1'b0;
    logic [8:0] m_h [2];
    logic [8:0] m_v [2];
    logic       m_fs [2];

    always @(posedge clk) begin
        m_tick     = cen & ~m_last_cen;
        m_last_cen = cen;
        m_rst      = !Reset_n;
        if (m_rst) m_live = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_fs[i] = 1'b0;
            if (m_rst) begin
                m_h[i] = PRM[i].hs;
                m_v[i] = PRM[i].vs;
            end else if (m_tick) begin
                if (m_h[i] == PRM[i].he) begin
                    m_h[i] = PRM[i].hs;
                    if (m_v[i] == PRM[i].ve) begin
                        m_v[i]  = PRM[i].vs;
                        m_fs[i] = 1'b1;
                    end else begin
                        m_v[i] = m_v[i] + 9'd1;
                    end
                end else begin
                    m_h[i] = m_h[i] + 9'd1;
                end
            end
        end
    end

    // ---------------- per-clk comparison plus line/frame period measurement ----------------
    int l_cnt = 0, hs_low = 0, ld_low = 0, f_cnt = 0;
    bit l_valid = 1'b0, f_valid = 1'b0;

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "outs_default" : "outs_small",
                    {8'd0, d_h[i], d_v[i], d_hb[i], d_vb[i], d_hs[i], d_vs[i], d_ld[i], d_fs[i]},
                    expv(i, m_h[i], m_v[i], m_fs[i]));
            end
            if (m_rst) begin
                l_valid = 1'b0; f_valid = 1'b0;
                l_cnt = 0; hs_low = 0; ld_low = 0; f_cnt = 0;
            end else if (m_tick) begin
                l_cnt++;
                if (!d_hs[0]) hs_low++;
                if (!d_ld[0]) ld_low++;
                if (m_h[0] == P0.hs) begin
                    if (l_valid) begin
                        chk("line_period", l_cnt, 384);
                        chk("hsync_width", hs_low, 32);
                        chk("line_ld_width", ld_low, 1);
                    end
                    l_valid = 1'b1; l_cnt = 0; hs_low = 0; ld_low = 0;
                end
                f_cnt++;
                if (m_fs[1]) begin
                    if (f_valid) chk("frame_period_small", f_cnt, 128);
                    f_valid = 1'b1; f_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        cen     = 1'b0;
        Reset_n = 1'b0;

        // Reset with cen toggling, released while cen is high.
        for (int k = 0; k < 4; k++) begin
            step();
            cen = ~cen;
        end
        step(); cen = 1'b1;
        step(); Reset_n = 1'b1;
        @(negedge clk);
        chk("rst_hcnt", d_h[0], 9'h080);
        chk("rst_vcnt", d_v[0], 9'h0F8);
        chk("rst_flags", {d_hb[0], d_vb[0], d_hs[0], d_vs[0], d_ld[0], d_fs[0]}, 6'b001110);

        // cen held high: no tick.
        repeat (20) step();
        @(negedge clk);
        chk("cen_hold_hcnt", d_h[0], 9'h080);

        // 1-high / 3-low cen: one increment per rising edge, visible 1 clk later.
        for (int i = 0; i < 8; i++) begin
            step(); cen = 1'b0;
            step(); step(); step(); cen = 1'b1;
            @(negedge clk);
            chk("tick_before", d_h[0], 9'h080 + i);
            step();
            @(negedge clk);
            chk("tick_after", d_h[0], 9'h081 + i);
        end
        chk("hblank_rise", d_hb[0], 1);

        // Randomised cen activity.
        repeat (30000) begin
            step();
            if ($urandom_range(0, 3) != 0) cen = ~cen;
        end

        // Run fast to hcnt=0x150, vcnt=0x120 on the default instance.
        found = 1'b0;
        for (int k = 0; k < 40000 && !found; k++) begin
            step();
            cen = ~cen;
            @(negedge clk);
            if (d_h[0] == 9'h150 && d_v[0] == 9'h120) found = 1'b1;
        end
        chk("reach_mid", {d_v[0], d_h[0]}, {9'h120, 9'h150});

        // One-clk reset pulse with cen high.
        Reset_n = 1'b0;
        cen     = 1'b1;
        step(); Reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_hcnt", d_h[0], 9'h080);
        chk("midrst_vcnt", d_v[0], 9'h0F8);
        chk("midrst_flags", {d_hb[0], d_vb[0], d_hs[0], d_vs[0], d_ld[0], d_fs[0]}, 6'b001110);
        repeat (5) step();
        @(negedge clk);
        chk("midrst_hold", d_h[0], 9'h080);
        step(); cen = 1'b0;
        step(); cen = 1'b1;
        @(negedge clk);
        chk("midrst_pre_tick", d_h[0], 9'h080);
        step();
        @(negedge clk);
        chk("midrst_first_tick", d_h[0], 9'h081);

        // Frame wrap on the small instance.
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            step();
            cen = ~cen;
            @(negedge clk);
            if (d_fs[1]) found = 1'b1;
        end
        chk("fwrap_pulse", d_fs[1], 1);
        chk("fwrap_hcnt", d_h[1], 9'h1F0);
        chk("fwrap_vcnt", d_v[1], 9'h1F8);
        chk("fwrap_line_ld", d_ld[1], 1);
        chk("fwrap_vblank", d_vb[1], 0);
        step();
        @(negedge clk);
        chk("fwrap_pulse_end", d_fs[1], 0);

        repeat (600) begin
            step();
            if ($urandom_range(0, 1) != 0) cen = ~cen;
        end
        finish_sim();
    end

endmodule

// File: doc/ttl_video_timing.md
# ttl_video_timing

Pixel-rate horizontal/vertical timing generator for the TTL-sync video chain, modelling the board's preset-reload 74LS163 H/V counter pair. Runs in the `clk` domain and advances on rising edges of the pixel enable `cen`. Produces the 9-bit H/V counts, active-low blank and sync, and a per-line load strobe. Directly feeds the 8-bit scroll/position counters: its `line_ld_n` drives their `load_n` and its `hblank_n` gates their `ent_n`/`enp_n`.

## Interface
- `H_START`, 9'h080, value hcnt reloads to after `H_END`
- `H_END`, 9'h1FF, last hcnt of a line
- `HBL_OFF`, 9'h088, hcnt at which hblank_n goes high (active video)
- `HBL_ON`, 9'h188, hcnt at which hblank_n goes low
- `HS_ON`, 9'h1A0, hcnt at which hsync_n goes low
- `HS_OFF`, 9'h1C0, hcnt at which hsync_n goes high
- `V_START`, 9'h0F8, value vcnt reloads to after `V_END`
- `V_END`, 9'h1FF, last vcnt of a frame
- `VBL_OFF`, 9'h100, vcnt at which vblank_n goes high
- `VBL_ON`, 9'h1F0, vcnt at which vblank_n goes low
- `VS_ON`, 9'h1F8, vcnt at which vsync_n goes low
- `VS_OFF`, 9'h1FC, vcnt at which vsync_n goes high
- `clk` in 1 system clock
- `Reset_n` in 1 synchronous, active-low reset
- `cen` in 1 pixel enable; a tick is a 0→1 transition sampled on `clk`
- `hcnt` out 9 horizontal count
- `vcnt` out 9 vertical count
- `hblank_n` out 1 low during horizontal blank
- `vblank_n` out 1 low during vertical blank
- `hsync_n` out 1 low during horizontal sync
- `vsync_n` out 1 low during vertical sync
- `line_ld_n` out 1 low while hcnt == H_END
- `frame_start` out 1 single-clk pulse at frame wrap

## Operation
- Tick detect: `last_cen <= cen` on every clk, including during reset. tick = `cen & ~last_cen`.
- Reset: Reset_n is sampled on every clk and is not gated by tick. It sets:
  - hcnt = H_START, vcnt = V_START
  - hblank_n = 0, vblank_n = 0, hsync_n = 1, vsync_n = 1
  - line_ld_n = 1, frame_start = 0
- Horizontal counting, on each tick:
  - hcnt == H_END → hcnt = H_START; otherwise hcnt + 1.
- Vertical counting, only on a tick where hcnt == H_END:
  - vcnt == V_END → vcnt = V_START; otherwise vcnt + 1.
- Flags are set/reset registers, evaluated on the next count value and updated in the same clk as the counts. They hold otherwise:
  - hblank_n = 1 when next hcnt == HBL_OFF; = 0 when == HBL_ON.
  - hsync_n = 0 at HS_ON; = 1 at HS_OFF.
  - vblank_n and vsync_n follow the same rule using next vcnt against VBL_*/VS_*.
  - V flags change only on line-wrap ticks.
- line_ld_n: registered, = 0 iff next hcnt == H_END. It therefore stays low for exactly one tick period.
- frame_start:
  - = 1 for one clk on the tick where both counts reload (hcnt H_END→H_START and vcnt V_END→V_START).
  - = 0 on all other clks.
- Parameter legality:
  - All ON/OFF values lie within [START, END] of their axis.
  - ON ≠ OFF for each pair.
  - START < END ≤ 9'h1FF, so the counts never overflow 9 bits.
  - Violations are not checked.
- Defaults give:
  - 384 ticks/line, 256 active pixels, 32-tick hsync.
  - 264 lines/frame, 240 active lines, 4-line vsync.

## Timing
- All outputs are registered. They change in the clk cycle that samples the tick (latency 1 clk from the cen rising edge).
- Downstream counters on the same `cen` sample the new values at the following tick. A load asserted at hcnt == H_END therefore takes effect at the tick where hcnt becomes H_START.
- cen held high or low produces no ticks. Counts and flags hold.
- Reset asserted mid-line: the next clk forces reset values regardless of cen.
- Reset release: no spurious tick is generated while cen stays high, because last_cen tracks cen throughout reset.
- Line wrap and frame wrap coinciding: H and V reloads, V flags, line_ld_n return to 1 and the frame_start pulse all occur in the same clk.

## Test plan
- Reset: Reset_n = 0 for 4 clk with cen toggling → hcnt = 0x080, vcnt = 0x0F8, hblank_n = 0, vblank_n = 0, hsync_n = 1, vsync_n = 1, line_ld_n = 1, frame_start = 0.
- Tick detection:
  - cen held at 1 for 20 clk → hcnt unchanged.
  - cen 1-high/3-low → hcnt +1 per cen rising edge, updated 1 clk after the edge.
- Line timing:
  - hblank_n rises at hcnt = 0x088 and falls at 0x188.
  - hsync_n low for exactly 32 ticks (0x1A0–0x1BF).
  - line_ld_n low only at hcnt = 0x1FF.
  - 384 ticks between successive hcnt = 0x080.
- Frame timing:
  - vblank_n high for vcnt 0x100–0x1EF (240 lines).
  - vsync_n low for vcnt 0x1F8–0x1FB.
  - frame_start pulses once every 101376 ticks, lasting 1 clk.
- Frame wrap: tick at hcnt = 0x1FF, vcnt = 0x1FF → hcnt = 0x080, vcnt = 0x0F8, frame_start = 1 for one clk, line_ld_n = 1, vblank_n stays 0.
- Reset mid-operation: at hcnt = 0x150, vcnt = 0x120, pulse Reset_n low 1 clk with cen high → reset values next clk. Next hcnt change occurs only at the next cen 0→1 transition.
